// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-handshake timeout.
// Strobes are decoded combinationally from the state and the current inputs.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        imem_ready,
  input  logic [31:0] instr_in,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        fault,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic [31:0] instret
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [2:0]  r_state, w_next, w_after;
  logic [7:0]  r_cnt;
  logic [31:0] r_ir, r_instret;
  logic        w_mem, w_tmo, w_retire, w_wait;
  assign w_mem    = MemRead | MemWrite;
  assign w_tmo    = r_cnt == TMO_LAST;
  assign w_wait   = r_state == S_FETCH || r_state == S_MEM;
  assign w_after  = run_en ? S_FETCH : S_IDLE;
  assign w_retire = (r_state == S_EXEC && !w_mem && !RegWrite) ||
                    (r_state == S_MEM && dmem_ready && !MemRead) ||
                    r_state == S_WB;
  assign imem_req = r_state == S_FETCH;
  assign ir_we    = r_state == S_FETCH && imem_ready;
  assign pc_we    = w_retire;
  assign pc_sel   = w_retire & Branch & branch_taken;
  assign dmem_re  = r_state == S_MEM && MemRead;
  assign dmem_we  = r_state == S_MEM && MemWrite;
  assign rf_we    = r_state == S_WB;
  assign fault    = r_state == S_FAULT;
  assign ir       = r_ir;
  assign state    = r_state;
  assign instret  = r_instret;
  // Ready on the final allowed wait cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = run_en ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = imem_ready ? S_DECODE : w_tmo ? S_FAULT : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (MemRead & MemWrite) ? S_FAULT : w_mem ? S_MEM : RegWrite ? S_WB : w_after;
      S_MEM:    w_next = dmem_ready ? (MemRead ? S_WB : w_after) : w_tmo ? S_FAULT : S_MEM;
      S_WB:     w_next = w_after;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= NOP_INSTR;
      r_instret <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_ir      <= ir_we ? instr_in : r_ir;
      r_instret <= w_retire ? r_instret + 32'd1 : r_instret;
      r_cnt     <= (w_next != r_state) ? 8'd0 : w_wait ? r_cnt + 8'd1 : r_cnt;
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream checked cycle by cycle against a queue of
// expected steps expanded from per-instruction-class latency and strobe rules.
module tb_multicycle_sequencer;
  localparam int unsigned TMO = 15;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [2:0] S_ID = 3'd0, S_FE = 3'd1, S_DE = 3'd2, S_EX = 3'd3, S_ME = 3'd4, S_WB = 3'd5, S_FA = 3'd6;
  localparam logic [7:0] IMR = 8'h80, IRW = 8'h40, PCW = 8'h20, PCS = 8'h10, DRE = 8'h08, DWE = 8'h04, RFW = 8'h02, FLT = 8'h01;
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] sb;
    logic       run;
    logic       irdy;
    logic       drdy;
    logic [3:0] ctl;
    logic       tk;
  } step_t;
  logic clk = 0, rst_n = 1, run_en = 0, imem_ready = 0, dmem_ready = 0, branch_taken = 0;
  logic Branch = 0, MemRead = 0, MemWrite = 0, RegWrite = 0;
  logic [31:0] instr_in = 0;
  logic imem_req, ir_we, pc_we, pc_sel, dmem_re, dmem_we, rf_we, fault;
  logic [31:0] ir, instret;
  logic [2:0] state;
  logic [7:0] w_sb;
  int checks = 0, errors = 0;
  logic [31:0] exp_ir = NOP, exp_instret = 0;
  step_t q[$];
  multicycle_sequencer #(.TIMEOUT(TMO), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .imem_ready(imem_ready), .instr_in(instr_in),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we),
    .fault(fault), .ir(ir), .state(state), .instret(instret)
  );
  assign w_sb = {imem_req, ir_we, pc_we, pc_sel, dmem_re, dmem_we, rf_we, fault};
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic rb();
    return $urandom_range(1, 0) == 1;
  endfunction
  function automatic logic [3:0] rc();
    return 4'($urandom);
  endfunction
  function automatic step_t mk(logic [2:0] st, logic [7:0] sb, logic run, logic irdy, logic drdy, logic [3:0] ctl, logic tk);
    return '{st, sb, run, irdy, drdy, ctl, tk};
  endfunction
  function automatic void add_fault();
    for (int k = 0; k < 3; k++) q.push_back(mk(S_FA, FLT, rb(), rb(), rb(), rc(), rb()));
  endfunction
  // kind: 0 branch, 1 alu+writeback, 2 alu no write, 3 load, 4 store, 5 illegal read+write.
  function automatic void add_instr(int kind, int iw, int dw, logic tk, logic stop);
    logic br, rd, wr, rw, run;
    logic [3:0] c;
    logic [7:0] ret, ms;
    br = kind == 0;
    rd = kind == 3 || kind == 5;
    wr = kind == 4 || kind == 5;
    rw = kind == 1 || kind == 3;
    c = {br, rd, wr, rw};
    run = !stop;
    ret = PCW | ((br & tk) ? PCS : 8'h00);
    ms = (rd ? DRE : 8'h00) | (wr ? DWE : 8'h00);
    for (int k = 0; k < iw && k < int'(TMO); k++) q.push_back(mk(S_FE, IMR, run, 1'b0, rb(), rc(), rb()));
    if (iw >= int'(TMO)) begin add_fault(); return; end
    q.push_back(mk(S_FE, IMR | IRW, run, 1'b1, rb(), rc(), rb()));
    q.push_back(mk(S_DE, 8'h00, run, rb(), rb(), rc(), rb()));
    if (rd && wr) begin
      q.push_back(mk(S_EX, 8'h00, run, rb(), rb(), c, tk));
      add_fault();
      return;
    end
    q.push_back(mk(S_EX, (rd || wr || rw) ? 8'h00 : ret, run, rb(), rb(), c, tk));
    if (rd || wr) begin
      for (int k = 0; k < dw && k < int'(TMO); k++) q.push_back(mk(S_ME, ms, run, rb(), 1'b0, c, tk));
      if (dw >= int'(TMO)) begin add_fault(); return; end
      q.push_back(mk(S_ME, ms | (rd ? 8'h00 : ret), run, rb(), 1'b1, c, tk));
    end
    if (rw) q.push_back(mk(S_WB, RFW | ret, run, rb(), rb(), c, tk));
    if (stop) begin
      q.push_back(mk(S_ID, 8'h00, 1'b0, rb(), rb(), rc(), rb()));
      q.push_back(mk(S_ID, 8'h00, 1'b1, rb(), rb(), rc(), rb()));
    end
  endfunction
  task automatic run_q();
    step_t s;
    logic [31:0] ins;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      ins = $urandom;
      run_en = s.run;
      imem_ready = s.irdy;
      dmem_ready = s.drdy;
      {Branch, MemRead, MemWrite, RegWrite} = s.ctl;
      branch_taken = s.tk;
      instr_in = ins;
      #1;
      chk("state", 32'(state), 32'(s.st));
      chk("strobes", 32'(w_sb), 32'(s.sb));
      chk("ir", ir, exp_ir);
      chk("instret", instret, exp_instret);
      if (s.sb[6]) exp_ir = ins;
      if (s.sb[5]) exp_instret = exp_instret + 32'd1;
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_state", 32'(state), 32'(S_ID));
    chk("rst_strobes", 32'(w_sb), 32'd0);
    chk("rst_ir", ir, NOP);
    chk("rst_instret", instret, 32'd0);
    {run_en, imem_ready, dmem_ready, Branch, MemRead, MemWrite, RegWrite, branch_taken} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_ir = NOP;
    exp_instret = 0;
  endtask
  initial begin
    #2;
    do_reset();
    q.push_back(mk(S_ID, 8'h00, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0));
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    add_instr(1, 0, 0, 1'b0, 1'b0);
    add_instr(3, 0, 3, 1'b0, 1'b0);
    add_instr(0, 0, 0, 1'b1, 1'b0);
    add_instr(4, 0, 0, 1'b0, 1'b0);
    add_instr(2, 0, 0, 1'b1, 1'b0);
    add_instr(1, int'(TMO) - 1, 0, 1'b0, 1'b0);
    add_instr(3, 1, int'(TMO) - 1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      add_instr($urandom_range(4, 0), $urandom_range(3, 0), $urandom_range(3, 0), rb(), $urandom_range(5, 0) == 0);
    add_instr(0, 0, 0, 1'b1, 1'b1);
    run_q();
    do_reset();
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    add_instr(1, int'(TMO), 0, 1'b0, 1'b0);
    run_q();
    do_reset();
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    add_instr(4, 0, int'(TMO), 1'b0, 1'b0);
    run_q();
    do_reset();
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    add_instr(5, 0, 0, 1'b0, 1'b0);
    run_q();
    do_reset();
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    q.push_back(mk(S_FE, IMR | IRW, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0));
    q.push_back(mk(S_DE, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0));
    q.push_back(mk(S_EX, 8'h00, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0));
    q.push_back(mk(S_ME, DWE, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0));
    q.push_back(mk(S_ME, DWE, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0));
    run_q();
    do_reset();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    q.push_back(mk(S_ID, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
    add_instr(0, 0, 0, 1'b1, 1'b1);
    run_q();
    chk("instret_wrap", instret, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
